// File: rtl/router_pkg.sv
// Shared constants, types and helpers for the N-channel router synchroniser.
package router_pkg;

  localparam int DEF_NUM_PORTS = 3;
  localparam int DEF_TIMEOUT   = 30;
  localparam int DEF_CNT_W     = 10;

  // Counter type of the per-channel soft-reset timer at its default width.
  typedef logic [DEF_CNT_W-1:0] sr_cnt_t;

  // Smallest address width that can name every channel (at least 1 bit).
  function automatic int min_addr_w(input int num_ports);
    int w;
    w = 1;
    while ((1 << w) < num_ports) w++;
    return w;
  endfunction

endpackage : router_pkg

// File: rtl/router_sync_timer.sv
// Per-channel read timeout: counts consecutive valid-but-unread cycles and
// emits a one-cycle soft_reset pulse every TIMEOUT cycles of an unbroken stall.
module router_sync_timer
  import router_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic clock,
  input  logic resetn,
  input  logic vld,
  input  logic rd,
  output logic soft_reset
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sr_q, sr_d;

  // Next count and pulse: any read or empty cycle restarts the count.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cnt_d = '0;
    sr_d  = 1'b0;
    if (vld && !rd) begin
      if (cnt_q == CNT_LAST) begin
        sr_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Counter and pulse registers.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      sr_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

  assign soft_reset = sr_q;

endmodule : router_sync_timer

// File: rtl/router_sync_n.sv
// N-channel router synchroniser: latches the destination address, steers the
// FSM write request to one FIFO, muxes its full flag back, drives vld_out and
// runs one read-timeout timer per channel.
// Optional: define ROUTER_SYNC_SR_STATUS_EN to add sr_clear / sr_status
// (sticky record of soft-reset pulses).
module router_sync_n
  import router_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int ADDR_W    = min_addr_w(DEF_NUM_PORTS),
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 detect_add,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 write_enb_reg,
  input  logic [NUM_PORTS-1:0] empty,
  input  logic [NUM_PORTS-1:0] full,
  input  logic [NUM_PORTS-1:0] read_enb,
`ifdef ROUTER_SYNC_SR_STATUS_EN
  input  logic                 sr_clear,
  output logic [NUM_PORTS-1:0] sr_status,
`endif
  output logic [NUM_PORTS-1:0] write_enb,
  output logic                 fifo_full,
  output logic                 addr_err,
  output logic [NUM_PORTS-1:0] vld_out,
  output logic [NUM_PORTS-1:0] soft_reset
);

  // NUM_PORTS fits in ADDR_W+1 bits because 2**ADDR_W >= NUM_PORTS.
  localparam logic [ADDR_W:0] NUM_PORTS_EXT = (ADDR_W + 1)'(NUM_PORTS);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              addr_vld_q, addr_vld_d;
  logic              addr_err_q, addr_err_d;
  logic              data_in_ok;
  logic              sr_hit;

  assign data_in_ok = ({1'b0, data_in} < NUM_PORTS_EXT);
  assign vld_out    = ~empty;

  // One read-timeout timer per channel.
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_timer
    router_sync_timer #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
    ) u_timer (
      .clock      (clock),
      .resetn     (resetn),
      .vld        (vld_out[i]),
      .rd         (read_enb[i]),
      .soft_reset (soft_reset[i])
    );
  end

  // Decode the latched address into write enable, full mux and soft-reset hit.
  always_comb begin
    write_enb = '0;
    fifo_full = 1'b0;
    sr_hit    = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (addr_vld_q && (addr_q == ADDR_W'(i))) begin
        write_enb[i] = write_enb_reg;
        fifo_full    = full[i];
        sr_hit       = soft_reset[i];
      end
    end
  end

  // Address capture wins over invalidation by a soft reset of the addressed channel.
  always_comb begin
    addr_d     = addr_q;
    addr_vld_d = addr_vld_q;
    addr_err_d = addr_err_q;
    if (detect_add) begin
      addr_d     = data_in;
      addr_vld_d = data_in_ok;
      addr_err_d = !data_in_ok;
    end else if (sr_hit) begin
      addr_vld_d = 1'b0;
    end
  end

  // Address latch registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_q     <= '0;
      addr_vld_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      addr_vld_q <= addr_vld_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign addr_err = addr_err_q;

`ifdef ROUTER_SYNC_SR_STATUS_EN
  logic [NUM_PORTS-1:0] sr_status_q, sr_status_d;

  // Sticky soft-reset record; a new pulse beats a simultaneous clear.
  always_comb begin
    sr_status_d = (sr_clear ? '0 : sr_status_q) | soft_reset;
  end

  // Status register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sr_status_q <= '0;
    end else begin
      sr_status_q <= sr_status_d;
    end
  end

  assign sr_status = sr_status_q;
`endif

endmodule : router_sync_n

// File: tb/tb_router_sync_n.sv
// Directed self-checking bench for router_sync_n at default parameters
// (3 ports, 2-bit address, timeout 30).
module tb_router_sync_n;

  localparam int NP = 3;
  localparam int AW = 2;

  logic          clock = 1'b0;
  logic          resetn;
  logic          detect_add;
  logic [AW-1:0] data_in;
  logic          write_enb_reg;
  logic [NP-1:0] empty, full, read_enb;
  logic [NP-1:0] write_enb, vld_out, soft_reset;
  logic          fifo_full, addr_err;
`ifdef ROUTER_SYNC_SR_STATUS_EN
  logic          sr_clear;
  logic [NP-1:0] sr_status;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  router_sync_n #(
    .NUM_PORTS (NP),
    .ADDR_W    (AW),
    .TIMEOUT   (30),
    .CNT_W     (10)
  ) dut (
    .clock         (clock),
    .resetn        (resetn),
    .detect_add    (detect_add),
    .data_in       (data_in),
    .write_enb_reg (write_enb_reg),
    .empty         (empty),
    .full          (full),
    .read_enb      (read_enb),
`ifdef ROUTER_SYNC_SR_STATUS_EN
    .sr_clear      (sr_clear),
    .sr_status     (sr_status),
`endif
    .write_enb     (write_enb),
    .fifo_full     (fifo_full),
    .addr_err      (addr_err),
    .vld_out       (vld_out),
    .soft_reset    (soft_reset)
  );

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic capture(input logic [AW-1:0] a);
    detect_add = 1'b1;
    data_in    = a;
    step();
    detect_add = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; detect_add = 1'b0; data_in = '0; write_enb_reg = 1'b0;
    empty = '1; full = '0; read_enb = '0;
`ifdef ROUTER_SYNC_SR_STATUS_EN
    sr_clear = 1'b0;
`endif
    step(); step();
    chk("reset_write_enb", 32'(write_enb), 32'h0);
    chk("reset_fifo_full", 32'(fifo_full), 32'h0);
    chk("reset_addr_err", 32'(addr_err), 32'h0);
    chk("reset_soft_reset", 32'(soft_reset), 32'h0);
    chk("reset_vld_out", 32'(vld_out), 32'h0);
`ifdef ROUTER_SYNC_SR_STATUS_EN
    chk("reset_sr_status", 32'(sr_status), 32'h0);
`endif
    resetn = 1'b1;
    step();
  endtask

  task automatic test_valid_addr();
    capture(2'd1);
    write_enb_reg = 1'b1; full = 3'b010; #1;
    chk("addr1_write_enb", 32'(write_enb), 32'h2);
    chk("addr1_fifo_full_set", 32'(fifo_full), 32'h1);
    chk("addr1_addr_err", 32'(addr_err), 32'h0);
    full = 3'b101; #1;
    chk("addr1_fifo_full_clr", 32'(fifo_full), 32'h0);
    step();
    write_enb_reg = 1'b0; #1;
    chk("addr1_write_enb_drop", 32'(write_enb), 32'h0);
    // Capture and write in the same cycle: write still uses the old address.
    detect_add = 1'b1; data_in = 2'd2; write_enb_reg = 1'b1; #1;
    chk("coincide_old_addr", 32'(write_enb), 32'h2);
    step();
    detect_add = 1'b0; #1;
    chk("coincide_new_addr", 32'(write_enb), 32'h4);
    write_enb_reg = 1'b0; full = '0;
  endtask

  task automatic test_invalid_addr();
    capture(2'd3);
    write_enb_reg = 1'b1; full = 3'b111; #1;
    chk("addr3_addr_err", 32'(addr_err), 32'h1);
    chk("addr3_write_enb", 32'(write_enb), 32'h0);
    chk("addr3_fifo_full", 32'(fifo_full), 32'h0);
    write_enb_reg = 1'b0; full = '0;
  endtask

  task automatic test_timeout();
    empty = 3'b101; read_enb = '0; #1;
    chk("stall_vld_out", 32'(vld_out), 32'h2);
    for (int k = 1; k <= 61; k++) begin
      step();
      chk($sformatf("timeout_edge%0d", k), 32'(soft_reset),
          (k == 30 || k == 60) ? 32'h2 : 32'h0);
    end
    empty = '1;
    step();
  endtask

  task automatic test_read_pulse();
    empty = 3'b101; read_enb = '0;
    for (int k = 1; k <= 51; k++) begin
      step();
      chk($sformatf("rdpulse_edge%0d", k), 32'(soft_reset), (k == 50) ? 32'h2 : 32'h0);
      read_enb = (k == 19) ? 3'b010 : 3'b000;
    end
    empty = '1; read_enb = '0;
    step();
  endtask

  task automatic test_invalidate();
`ifdef ROUTER_SYNC_SR_STATUS_EN
    sr_clear = 1'b1; step(); sr_clear = 1'b0;
`endif
    capture(2'd2);
    empty = 3'b011; write_enb_reg = 1'b1; full = 3'b100;
    for (int k = 1; k <= 29; k++) begin
      step();
      if (k == 1 || k == 29) chk($sformatf("inval_pre_we%0d", k), 32'(write_enb), 32'h4);
    end
    step();
    chk("inval_pulse", 32'(soft_reset), 32'h4);
    chk("inval_pulse_we", 32'(write_enb), 32'h4);
    step();
    chk("inval_after_we", 32'(write_enb), 32'h0);
    chk("inval_after_full", 32'(fifo_full), 32'h0);
`ifdef ROUTER_SYNC_SR_STATUS_EN
    chk("sr_status_set", 32'(sr_status[2]), 32'h1);
    sr_clear = 1'b1; step(); sr_clear = 1'b0;
    chk("sr_status_clr", 32'(sr_status), 32'h0);
`endif
    empty = '1;
    capture(2'd0); #1;
    chk("inval_restore_we", 32'(write_enb), 32'h1);
    write_enb_reg = 1'b0; full = '0;
  endtask

  task automatic test_async_reset();
    capture(2'd3);
    empty = 3'b101; read_enb = '0;
    for (int k = 1; k <= 15; k++) step();
    chk("arst_pre_err", 32'(addr_err), 32'h1);
    #2 resetn = 1'b0;
    #1;
    chk("arst_addr_err", 32'(addr_err), 32'h0);
    chk("arst_soft_reset", 32'(soft_reset), 32'h0);
    step();
    resetn = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      step();
      chk($sformatf("arst_edge%0d", k), 32'(soft_reset), (k == 30) ? 32'h2 : 32'h0);
    end
    empty = '1;
    step();
  endtask

  initial begin
    test_reset();
    test_valid_addr();
    test_invalid_addr();
    test_timeout();
    test_read_pulse();
    test_invalidate();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_router_sync_n
